mem1port_arbiter: RTL and testbench
===================================

Name: mem1port_arbiter

Overview:
- Shares one single-port testbench/SoC memory (mem1port style: ready/we/addr/wdata/wstrb in; rresp/rdata out, 1-cycle read latency, posted writes) between the instruction-fetch port (read-only) and the data port (read/write).
- Sits between the core's I/D buses and the memory when SINGLE_RAM is built.
- Data-port priority, with a starvation limit that guarantees forward progress for fetch.
- Routes each read response to the port that issued it.

Parameters:
- MAX_WAIT, 4: consecutive cycles the I-port may be denied while requesting before it wins priority (range 1..255).
- CNTW, 8: width of the starvation counter; must satisfy 2^CNTW > MAX_WAIT.

Ports:
- clk  in  1  clock
- resetb  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request; i_addr stable until granted
- i_addr  in  30  fetch word address [31:2]
- i_gnt  out  1  fetch request accepted this cycle
- i_rresp  out  1  fetch read data valid
- i_rdata  out  32  fetch read data
- d_req  in  1  data request; d_* stable until granted
- d_we  in  1  1 = write, 0 = read
- d_addr  in  30  data word address [31:2]
- d_wdata  in  32  write data
- d_wstrb  in  4  byte strobes
- d_gnt  out  1  data request accepted this cycle
- d_rresp  out  1  data read data valid
- d_rdata  out  32  data read data
- m_ready  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_addr  out  30  memory word address
- m_wdata  out  32  memory write data
- m_wstrb  out  4  memory strobes
- m_rresp  in  1  memory read valid, 1 cycle after read issue
- m_rdata  in  32  memory read data

Behaviour:
- Reset, asynchronous, resetb low:
  - starv_cnt = 0; rd_owner = OWN_NONE.
  - i_rresp = d_rresp = 0.
  - Grant and memory outputs are combinational, derived from the state above.
- Arbitration is combinational, one access per cycle, no bubbles:
  - sel_i = i_req && (!d_req || starv_cnt >= MAX_WAIT).
  - sel_d = d_req && !sel_i.
  - i_gnt = sel_i; d_gnt = sel_d; m_ready = sel_i | sel_d.
- Memory mux:
  - If sel_i: m_we=0, m_addr=i_addr, m_wstrb=0, m_wdata=0.
  - If sel_d: d_* forwarded.
  - If idle: m_addr, m_wdata, m_wstrb, m_we = 0.
- Starvation counter:
  - Increments (saturating at 2^CNTW-1) when i_req && !sel_i.
  - Clears when sel_i or !i_req.
  - With MAX_WAIT=N, fetch waits at most N cycles.
- Response routing register, rd_owner at posedge:
  - OWN_I if sel_i.
  - OWN_D if sel_d && !d_we.
  - Otherwise OWN_NONE. Writes never generate a response.
- Response outputs:
  - i_rresp = m_rresp && rd_owner==OWN_I; d_rresp = m_rresp && rd_owner==OWN_D.
  - i_rdata = d_rdata = m_rdata; the consumer qualifies with its rresp.
- Read latency: grant in cycle n, rresp/rdata in cycle n+1. Back-to-back reads from alternating owners route correctly.
- Ordering:
  - A D write granted in cycle n is visible to any read granted in n+1 or later.
  - No reordering: requests are serviced strictly in grant order.
- Simultaneous requests with starv_cnt < MAX_WAIT: D wins, I stalls.
- m_rresp with rd_owner==OWN_NONE (protocol error): dropped, both rresp stay 0; simulation-only $display warning.
- Reset mid-read: rd_owner cleared, so any pending response is suppressed. Requesters must reissue after reset.

Decomposition:
- Shared package holds:
  - Owner encoding, 2 bits: OWN_NONE=0, OWN_I=1, OWN_D=2.
  - Default MAX_WAIT constant.
- No sub-module. Arbitration, counter and routing fit in one module of about 150 lines.

Test Plan:
- Only i_req, i_addr=0x4 (word holding 0x00000013) -> i_gnt=1 same cycle, m_ready=1, m_we=0; next cycle i_rresp=1, i_rdata=0x00000013, d_rresp=0.
- i_req and d_req (read 0x100) together, starv_cnt=0 -> d_gnt=1, i_gnt=0; next cycle d_rresp=1 only; I granted the following cycle once d_req drops.
- d_req held every cycle, i_req held, MAX_WAIT=4 -> i_gnt on the 5th cycle; starv_cnt returns to 0; D regains the grant next cycle.
- D write 0x20 data 0xDEADBEEF wstrb 0xF in cycle n, I read 0x20 in n+1 -> i_rresp in n+2 with 0xDEADBEEF; no d_rresp for the write.
- Alternating D read 0x40 / I read 0x44 every cycle -> each rresp lands on the issuing port with the correct word, zero bubbles.
- resetb low for one cycle right after an I read grant -> i_rresp stays 0; starv_cnt=0 and rd_owner=OWN_NONE after release.

Source files
------------

// File: rtl/mem1port_arbiter_pkg.sv
// Shared definitions for the single-port memory arbiter: read-response owner
// encoding and the default fetch starvation limit.
package mem1port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam int unsigned MAX_WAIT_DEFAULT = 4;
    localparam int unsigned CNTW_DEFAULT     = 8;

endpackage

// File: rtl/mem1port_arbiter_if.sv
// Bus bundle for the arbiter: fetch port, data port and shared memory port.
// slave = arbiter view, master = core/memory environment view.
interface mem1port_arbiter_if;

    logic        i_req;
    logic [29:0] i_addr;
    logic        i_gnt;
    logic        i_rresp;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [29:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt;
    logic        d_rresp;
    logic [31:0] d_rdata;

    logic        m_ready;
    logic        m_we;
    logic [29:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_rresp;
    logic [31:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rresp, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rresp, d_rdata,
        output m_ready, m_we, m_addr, m_wdata, m_wstrb,
        input  m_rresp, m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rresp, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rresp, d_rdata,
        input  m_ready, m_we, m_addr, m_wdata, m_wstrb,
        output m_rresp, m_rdata
    );

endinterface

// File: rtl/mem1port_arbiter.sv
// Shares one single-port memory between fetch (read-only) and data ports.
// Data port has priority; fetch wins after MAX_WAIT consecutive denials.
module mem1port_arbiter
    import mem1port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
    parameter int unsigned CNTW     = CNTW_DEFAULT
) (
    input  logic              clk,
    input  logic              resetb,
    mem1port_arbiter_if.slave bus
);

    logic [CNTW-1:0] starv_cnt;
    logic [CNTW-1:0] starv_cnt_nxt;
    owner_e          rd_owner;
    owner_e          rd_owner_nxt;
    logic            sel_i;
    logic            sel_d;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            starv_cnt <= '0;
            rd_owner  <= OWN_NONE;
        end else begin
            starv_cnt <= starv_cnt_nxt;
            rd_owner  <= rd_owner_nxt;
        end
    end

    always_comb begin
        sel_i = bus.i_req && (!bus.d_req || (starv_cnt >= CNTW'(MAX_WAIT)));
        sel_d = bus.d_req && !sel_i;

        bus.i_gnt   = sel_i;
        bus.d_gnt   = sel_d;
        bus.m_ready = sel_i | sel_d;

        bus.m_we    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_wstrb = '0;
        if (sel_i) begin
            bus.m_addr = bus.i_addr;
        end else if (sel_d) begin
            bus.m_we    = bus.d_we;
            bus.m_addr  = bus.d_addr;
            bus.m_wdata = bus.d_wdata;
            bus.m_wstrb = bus.d_wstrb;
        end
    end

    // Counter only runs while fetch is actively being denied; saturates.
    always_comb begin
        starv_cnt_nxt = starv_cnt;
        if (!bus.i_req || sel_i) begin
            starv_cnt_nxt = '0;
        end else if (starv_cnt != '1) begin
            starv_cnt_nxt = starv_cnt + 1'b1;
        end
    end

    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (sel_i) begin
            rd_owner_nxt = OWN_I;
        end else if (sel_d && !bus.d_we) begin
            rd_owner_nxt = OWN_D;
        end
    end

    always_comb begin
        bus.i_rresp = bus.m_rresp && (rd_owner == OWN_I);
        bus.d_rresp = bus.m_rresp && (rd_owner == OWN_D);
        bus.i_rdata = bus.m_rdata;
        bus.d_rdata = bus.m_rdata;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (resetb && bus.m_rresp && (rd_owner == OWN_NONE))
            $warning("mem1port_arbiter: unowned read response dropped");
    end
`endif

endmodule

// File: tb/tb_mem1port_arbiter.sv
// Directed bench for mem1port_arbiter with a small 1-cycle-latency memory.
module tb_mem1port_arbiter;
    import mem1port_arbiter_pkg::*;

    logic clk;
    logic resetb;
    int   tests;
    int   fails;

    mem1port_arbiter_if bus ();

    mem1port_arbiter #(
        .MAX_WAIT(4),
        .CNTW    (8)
    ) dut (
        .clk   (clk),
        .resetb(resetb),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory environment: posted byte-strobed writes, reads answered next cycle.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (!resetb) begin
            mem[10'h004] <= 32'h0000_0013;
            mem[10'h008] <= 32'h8888_8888;
            mem[10'h100] <= 32'hCAFE_0100;
            mem[10'h040] <= 32'h4040_4040;
            mem[10'h044] <= 32'h4444_4444;
            mem[10'h020] <= 32'h0;
            bus.m_rresp  <= 1'b0;
            bus.m_rdata  <= '0;
        end else begin
            bus.m_rresp <= bus.m_ready && !bus.m_we;
            if (bus.m_ready && !bus.m_we)
                bus.m_rdata <= mem[bus.m_addr[9:0]];
            if (bus.m_ready && bus.m_we) begin
                if (bus.m_wstrb[0]) mem[bus.m_addr[9:0]][7:0]   <= bus.m_wdata[7:0];
                if (bus.m_wstrb[1]) mem[bus.m_addr[9:0]][15:8]  <= bus.m_wdata[15:8];
                if (bus.m_wstrb[2]) mem[bus.m_addr[9:0]][23:16] <= bus.m_wdata[23:16];
                if (bus.m_wstrb[3]) mem[bus.m_addr[9:0]][31:24] <= bus.m_wdata[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        resetb      = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_wstrb = '0;

        tick();
        tick();
        chk("rst_starv", 32'(dut.starv_cnt), 0);
        chk("rst_owner", 32'(dut.rd_owner), 32'(OWN_NONE));
        chk("rst_i_rresp", 32'(bus.i_rresp), 0);
        chk("rst_d_rresp", 32'(bus.d_rresp), 0);
        chk("rst_m_ready", 32'(bus.m_ready), 0);
        resetb = 1'b1;
        tick();

        // Fetch alone
        bus.i_req = 1'b1; bus.i_addr = 30'h4;
        #1;
        chk("t1_i_gnt", 32'(bus.i_gnt), 1);
        chk("t1_m_ready", 32'(bus.m_ready), 1);
        chk("t1_m_we", 32'(bus.m_we), 0);
        chk("t1_m_addr", 32'(bus.m_addr), 32'h4);
        tick();
        chk("t1_i_rresp", 32'(bus.i_rresp), 1);
        chk("t1_i_rdata", bus.i_rdata, 32'h0000_0013);
        chk("t1_d_rresp", 32'(bus.d_rresp), 0);
        bus.i_req = 1'b0;
        tick();

        // Simultaneous: data wins, fetch follows when data drops
        bus.i_req = 1'b1; bus.i_addr = 30'h8;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 30'h100;
        #1;
        chk("t2_d_gnt", 32'(bus.d_gnt), 1);
        chk("t2_i_gnt", 32'(bus.i_gnt), 0);
        chk("t2_m_addr", 32'(bus.m_addr), 32'h100);
        tick();
        chk("t2_d_rresp", 32'(bus.d_rresp), 1);
        chk("t2_d_rdata", bus.d_rdata, 32'hCAFE_0100);
        chk("t2_i_rresp", 32'(bus.i_rresp), 0);
        bus.d_req = 1'b0;
        #1;
        chk("t2_i_gnt_after", 32'(bus.i_gnt), 1);
        tick();
        chk("t2_i_rresp_after", 32'(bus.i_rresp), 1);
        chk("t2_i_rdata_after", bus.i_rdata, 32'h8888_8888);
        bus.i_req = 1'b0;
        tick();

        // Starvation limit: fetch wins on 5th contested cycle
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 30'h40;
        bus.i_req = 1'b1; bus.i_addr = 30'h44;
        #1;
        for (int c = 1; c <= 4; c++) begin
            chk("t3_d_gnt_wait", 32'(bus.d_gnt), 1);
            chk("t3_i_gnt_wait", 32'(bus.i_gnt), 0);
            tick();
            chk("t3_d_rresp_wait", 32'(bus.d_rresp), 1);
        end
        chk("t3_starv_4", 32'(dut.starv_cnt), 4);
        chk("t3_i_gnt_5th", 32'(bus.i_gnt), 1);
        chk("t3_d_gnt_5th", 32'(bus.d_gnt), 0);
        tick();
        chk("t3_starv_clr", 32'(dut.starv_cnt), 0);
        chk("t3_i_rresp", 32'(bus.i_rresp), 1);
        chk("t3_i_rdata", bus.i_rdata, 32'h4444_4444);
        chk("t3_d_regain", 32'(bus.d_gnt), 1);
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        tick();

        // Write then immediate fetch of same word
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 30'h20;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'hF;
        #1;
        chk("t4_d_gnt", 32'(bus.d_gnt), 1);
        chk("t4_m_we", 32'(bus.m_we), 1);
        chk("t4_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
        chk("t4_m_wstrb", 32'(bus.m_wstrb), 32'hF);
        tick();
        chk("t4_wr_no_rresp", 32'(bus.d_rresp), 0);
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = '0; bus.d_wstrb = '0;
        bus.i_req = 1'b1; bus.i_addr = 30'h20;
        #1;
        chk("t4_i_gnt", 32'(bus.i_gnt), 1);
        chk("t4_m_wdata_i", bus.m_wdata, 0);
        tick();
        chk("t4_i_rresp", 32'(bus.i_rresp), 1);
        chk("t4_i_rdata", bus.i_rdata, 32'hDEAD_BEEF);
        chk("t4_d_rresp", 32'(bus.d_rresp), 0);
        bus.i_req = 1'b0;
        tick();

        // Alternating owners every cycle
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 30'h40;
            end else begin
                bus.d_req = 1'b0;
                bus.i_req = 1'b1; bus.i_addr = 30'h44;
            end
            #1;
            chk("t5_m_ready", 32'(bus.m_ready), 1);
            tick();
            if (k % 2 == 0) begin
                chk("t5_d_rresp", 32'(bus.d_rresp), 1);
                chk("t5_i_rresp_q", 32'(bus.i_rresp), 0);
                chk("t5_d_rdata", bus.d_rdata, 32'h4040_4040);
            end else begin
                chk("t5_i_rresp", 32'(bus.i_rresp), 1);
                chk("t5_d_rresp_q", 32'(bus.d_rresp), 0);
                chk("t5_i_rdata", bus.i_rdata, 32'h4444_4444);
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        #1;
        chk("idle_m_ready", 32'(bus.m_ready), 0);
        chk("idle_m_addr", 32'(bus.m_addr), 0);
        chk("idle_m_we", 32'(bus.m_we), 0);
        tick();

        // Reset right after a fetch grant suppresses its response
        bus.i_req = 1'b1; bus.i_addr = 30'h4;
        #1;
        chk("t6_i_gnt", 32'(bus.i_gnt), 1);
        tick();
        bus.i_req = 1'b0;
        resetb = 1'b0;
        #1;
        chk("t6_owner_rst", 32'(dut.rd_owner), 32'(OWN_NONE));
        chk("t6_i_rresp_rst", 32'(bus.i_rresp), 0);
        tick();
        resetb = 1'b1;
        #1;
        chk("t6_starv_rel", 32'(dut.starv_cnt), 0);
        chk("t6_owner_rel", 32'(dut.rd_owner), 32'(OWN_NONE));
        chk("t6_i_rresp_rel", 32'(bus.i_rresp), 0);
        tick();
        chk("t6_i_rresp_late", 32'(bus.i_rresp), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
